// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port among NUM_REQ fetch units,
// with burst lock and a ROM_LAT-deep tag pipeline; define ROM_ARB_BG_PRIORITY_EN for bg priority.
module rom_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ROM_ARB_BG_PRIORITY_EN
    localparam bit BG_PRI = 1'b1;
`else
    localparam bit BG_PRI = 1'b0;
`endif

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     owner_reg, owner_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next;
    logic [ADDR_W-1:0]   last_addr_reg;
    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    logic                grant_live;
    logic                rr_found;
    logic [ID_W-1:0]     rr_id;
    logic [ID_W-1:0]     rr_cand;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic                tag_valid_reg [ROM_LAT];
    logic [ID_W-1:0]     tag_id_reg [ROM_LAT];

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
            assign gnt[gi]      = grant_live && (grant_id == ID_W'(gi));
            assign rvalid[gi]   = tag_valid_reg[ROM_LAT-1] && (tag_id_reg[ROM_LAT-1] == ID_W'(gi));
        end
    endgenerate

    // Search starts at ptr and wraps at NUM_REQ, which need not be a power of two.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        rr_cand  = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_id    = rr_cand;
            end
            rr_cand = wrap_inc(rr_cand);
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        grant_any  = 1'b0;
        grant_id   = '0;
        // Background preempts anyone but itself; a preempted owner keeps its burst.
        if (BG_PRI && req[0] && !(state_reg == OWNED && owner_reg == '0)) begin
            grant_any = 1'b1;
            grant_id  = '0;
            if (state_reg == IDLE && lock[0]) begin
                state_next = OWNED;
                owner_next = '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rr_found) begin
                        grant_any = 1'b1;
                        grant_id  = rr_id;
                        ptr_next  = wrap_inc(rr_id);
                        if (lock[rr_id]) begin
                            state_next = OWNED;
                            owner_next = rr_id;
                        end
                    end
                end
                OWNED: begin
                    if (req[owner_reg]) begin
                        grant_any = 1'b1;
                        grant_id  = owner_reg;
                        if (!lock[owner_reg]) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Grants are masked while reset is held, even though req may already be active.
    assign grant_live = grant_any && Reset;
    assign rom_addr   = grant_live ? addr_arr[grant_id] : last_addr_reg;
    assign rdata      = tag_valid_reg[ROM_LAT-1] ? rom_data : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            ptr_reg       <= '0;
            last_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            if (grant_live) begin
                last_addr_reg <= rom_addr;
            end
        end
    end

    // Tag pipeline is exactly as deep as the ROM, so rvalid lines up with rom_data.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_valid_reg[s] <= 1'b0;
                tag_id_reg[s]    <= '0;
            end
        end else begin
            tag_valid_reg[0] <= grant_live;
            tag_id_reg[0]    <= grant_id;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_id_reg[s]    <= tag_id_reg[s-1];
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized bench for rom_port_arbiter against a queue-based reference model and a
// latency-accurate ROM model; honours ROM_ARB_BG_PRIORITY_EN in the model as well.
module tb_rom_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 2;

    logic                      Clk = 1'b0;
    logic                      Reset = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ-1:0]        lock = '0;
    logic [NUM_REQ*ADDR_W-1:0] addr = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;

    rom_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .lock(lock), .addr(addr),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return DATA_W'((x * 32'd37) ^ (x >> 5) ^ (x >> 13));
    endfunction

    // ROM with ROM_LAT registered stages.
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= rom_fn(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    typedef struct {
        bit                v;
        int                id;
        logic [ADDR_W-1:0] a;
    } rec_t;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                ptr;
    int                owner;
    logic [ADDR_W-1:0] last_addr;
    rec_t              hist[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        ptr       = 0;
        owner     = -1;
        last_addr = '0;
        hist.delete();
    endtask

    function automatic logic [NUM_REQ*ADDR_W-1:0] put(input logic [NUM_REQ*ADDR_W-1:0] av,
                                                       input int i, input int a);
        logic [NUM_REQ*ADDR_W-1:0] r;
        r = av;
        r[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        return r;
    endfunction

    function automatic logic [NUM_REQ*ADDR_W-1:0] rand_addrs();
        logic [NUM_REQ*ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) r[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        return r;
    endfunction

    // Called at posedge+1; drives one cycle and checks it at the negedge.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                        input logic [NUM_REQ*ADDR_W-1:0] av);
        int                g;
        bit                pri;
        rec_t              rc;
        logic [ADDR_W-1:0] exp_addr;
        req  = r;
        lock = l;
        addr = av;
        @(negedge Clk);
        g   = -1;
        pri = 1'b0;
`ifdef ROM_ARB_BG_PRIORITY_EN
        if (r[0] && owner != 0) begin
            g   = 0;
            pri = 1'b1;
            if (owner < 0 && l[0]) owner = 0;
        end
`endif
        if (!pri) begin
            if (owner >= 0) begin
                if (r[owner]) begin
                    g = owner;
                    if (!l[owner]) owner = -1;
                end else begin
                    owner = -1;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int j;
                    j = (ptr + k) % NUM_REQ;
                    if (g < 0 && r[j]) g = j;
                end
                if (g >= 0) begin
                    ptr = (g + 1) % NUM_REQ;
                    if (l[g]) owner = g;
                end
            end
        end
        exp_addr = (g >= 0) ? av[g*ADDR_W +: ADDR_W] : last_addr;
        check_eq("gnt", 64'(gnt), (g >= 0) ? 64'(1) << g : 64'(0));
        check_eq("rom_addr", 64'(rom_addr), 64'(exp_addr));
        rc.v = 1'b0; rc.id = 0; rc.a = '0;
        if (hist.size() >= ROM_LAT) rc = hist[hist.size() - ROM_LAT];
        check_eq("rvalid", 64'(rvalid), rc.v ? 64'(1) << rc.id : 64'(0));
        if (rc.v) begin
            check_eq("rdata", 64'(rdata), 64'(rom_fn(rc.a)));
            $display("txn cyc=%0d id=%0d addr=%0h data=%0h", cyc, rc.id, rc.a, rdata);
        end
        hist.push_back('{v: (g >= 0), id: (g >= 0) ? g : 0, a: exp_addr});
        if (hist.size() > ROM_LAT) void'(hist.pop_front());
        if (g >= 0) last_addr = exp_addr;
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Called at posedge+1; asserts reset asynchronously for n cycles with requests active.
    task automatic do_reset(input int n, input logic [NUM_REQ-1:0] r);
        Reset = 1'b0;
        req   = r;
        lock  = r;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            check_eq("rst_gnt", 64'(gnt), 64'(0));
            check_eq("rst_rvalid", 64'(rvalid), 64'(0));
            check_eq("rst_rdata", 64'(rdata), 64'(0));
            check_eq("rst_rom_addr", 64'(rom_addr), 64'(0));
            @(posedge Clk);
            #1;
            cyc++;
        end
        Reset = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [NUM_REQ*ADDR_W-1:0] av;
        model_clear();
        #1;
        // Reset held with all requests, then round-robin 1,2,4,8,...
        do_reset(3, 4'hF);
        av = '0;
        for (int i = 0; i < NUM_REQ; i++) av = put(av, i, 16'h1000 * (i + 1) + i);
        for (int i = 0; i < 9; i++) step(4'hF, 4'h0, av);
        for (int i = 0; i < ROM_LAT; i++) step(4'h0, 4'h0, av);

        // Burst of three by requester 2, requester 1 waiting.
        do_reset(1, 4'h0);
        step(4'b0100, 4'b0100, put(av, 2, 96));
        step(4'b0110, 4'b0100, put(av, 2, 97));
        step(4'b0110, 4'b0000, put(av, 2, 98));
        step(4'b0010, 4'b0000, av);
        for (int i = 0; i < ROM_LAT; i++) step(4'h0, 4'h0, av);

        // Owner 3 drops req for one cycle while requester 0 waits.
        step(4'b1000, 4'b1000, av);
        step(4'b0001, 4'b0000, av);
        step(4'b0001, 4'b0000, av);
        for (int i = 0; i < ROM_LAT; i++) step(4'h0, 4'h0, av);

        // Reset one cycle after a grant: the in-flight beat must vanish.
        step(4'b0010, 4'b0000, put(av, 1, 55));
        do_reset(1, 4'h0);
        for (int i = 0; i < ROM_LAT + 1; i++) step(4'h0, 4'h0, av);

        // Owner 2 bursting while requester 0 pulses.
        step(4'b0100, 4'b0100, put(av, 2, 200));
        step(4'b0101, 4'b0100, put(av, 2, 201));
        step(4'b0100, 4'b0100, put(av, 2, 202));
        step(4'b0100, 4'b0000, put(av, 2, 203));
        for (int i = 0; i < ROM_LAT; i++) step(4'h0, 4'h0, av);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(1, 2), NUM_REQ'($urandom));
            end else begin
                step(NUM_REQ'($urandom), NUM_REQ'($urandom & $urandom), rand_addrs());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
